// File: rtl/cc_flag_unit.sv
// cc_flag_unit
//   Consumer end of the ALU_CC flag outputs. Holds the architectural condition
//   code register {N,Z,V,C}, feeds the stored carry back as Pre_C, keeps a
//   one-deep shadow copy for interrupt entry/return, and evaluates branch
//   conditions with a one-cycle registered result.
//
// Ports
//   CLK, RST_N            clock (rising edge), async active-low reset
//   Z_in/V_in/C_in/N_in   ALU flags
//   FLAG_WE[3:0]          per-flag write enable {N,Z,V,C}
//   SET_C / CLR_C         force carry to 1 / 0 (both together: no change)
//   SAVE / RESTORE        flags -> shadow / shadow -> flags
//   BR_VALID, BR_COND     branch request and condition code
//   BR_OFS, PC            signed word offset, branch instruction address
//   Pre_C                 stored carry (combinational from FLAGS[0])
//   FLAGS[3:0]            stored {N,Z,V,C}
//   SHADOW_VALID          shadow holds saved flags
//   BR_DONE               one-cycle result pulse
//   BR_TAKEN, BR_TARGET   branch decision and target, valid with BR_DONE
module cc_flag_unit #(
   parameter int PC_W  = 16,
   parameter int OFS_W = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             Z_in,
   input  logic             V_in,
   input  logic             C_in,
   input  logic             N_in,
   input  logic [3:0]       FLAG_WE,
   input  logic             SET_C,
   input  logic             CLR_C,
   input  logic             SAVE,
   input  logic             RESTORE,
   input  logic             BR_VALID,
   input  logic [3:0]       BR_COND,
   input  logic [OFS_W-1:0] BR_OFS,
   input  logic [PC_W-1:0]  PC,
   output logic             Pre_C,
   output logic [3:0]       FLAGS,
   output logic             SHADOW_VALID,
   output logic             BR_DONE,
   output logic             BR_TAKEN,
   output logic [PC_W-1:0]  BR_TARGET
);

   localparam int N_B = 3;
   localparam int Z_B = 2;
   localparam int V_B = 1;
   localparam int C_B = 0;

   logic [3:0]      flags_q;
   logic [3:0]      shadow_q;
   logic            shadow_vld_q;
   logic [3:0]      flags_nxt;
   logic [3:0]      alu_flags;
   logic            do_restore;
   logic            cond_true;
   logic [PC_W-1:0] ofs_ext;
   logic [PC_W-1:0] target_nxt;

   assign alu_flags  = {N_in, Z_in, V_in, C_in};
   assign do_restore = RESTORE & shadow_vld_q;

   // Next flag value; SAVE snapshots this post-update value.
   always_comb begin
      flags_nxt = flags_q;
      if (do_restore) begin
         flags_nxt = shadow_q;
      end else begin
         for (int i = 0; i < 4; i++)
            if (FLAG_WE[i]) flags_nxt[i] = alu_flags[i];
         // SET_C/CLR_C override the carry write; both at once cancel to hold.
         if (SET_C && CLR_C)  flags_nxt[C_B] = flags_q[C_B];
         else if (SET_C)      flags_nxt[C_B] = 1'b1;
         else if (CLR_C)      flags_nxt[C_B] = 1'b0;
      end
   end

   // Conditions look at the flags as stored before this edge.
   always_comb begin
      logic n, z, v, c;
      n = flags_q[N_B];
      z = flags_q[Z_B];
      v = flags_q[V_B];
      c = flags_q[C_B];
      cond_true = 1'b0;
      case (BR_COND)
         4'd0:  cond_true = z;
         4'd1:  cond_true = ~z;
         4'd2:  cond_true = c;
         4'd3:  cond_true = ~c;
         4'd4:  cond_true = n;
         4'd5:  cond_true = ~n;
         4'd6:  cond_true = v;
         4'd7:  cond_true = ~v;
         4'd8:  cond_true = c & ~z;
         4'd9:  cond_true = ~c | z;
         4'd10: cond_true = (n == v);
         4'd11: cond_true = (n != v);
         4'd12: cond_true = ~z & (n == v);
         4'd13: cond_true = z | (n != v);
         4'd14: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   assign ofs_ext    = {{(PC_W-OFS_W){BR_OFS[OFS_W-1]}}, BR_OFS};
   assign target_nxt = PC + PC_W'(1) + ofs_ext;   // wraps modulo 2^PC_W

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         flags_q      <= '0;
         shadow_q     <= '0;
         shadow_vld_q <= 1'b0;
         BR_DONE      <= 1'b0;
         BR_TAKEN     <= 1'b0;
         BR_TARGET    <= '0;
      end else begin
         flags_q <= flags_nxt;
         if (do_restore) begin
            shadow_vld_q <= 1'b0;
         end else if (SAVE && !RESTORE) begin
            shadow_q     <= flags_nxt;
            shadow_vld_q <= 1'b1;
         end
         BR_DONE  <= BR_VALID;
         BR_TAKEN <= BR_VALID & cond_true;
         if (BR_VALID) BR_TARGET <= target_nxt;
      end
   end

   assign FLAGS        = flags_q;
   assign Pre_C        = flags_q[C_B];
   assign SHADOW_VALID = shadow_vld_q;

endmodule

// File: tb/tb_cc_flag_unit.sv
module tb_cc_flag_unit;
   localparam int PC_W  = 16;
   localparam int OFS_W = 8;

   logic             CLK = 1'b0;
   logic             RST_N = 1'b0;
   logic             Z_in, V_in, C_in, N_in;
   logic [3:0]       FLAG_WE;
   logic             SET_C, CLR_C, SAVE, RESTORE;
   logic             BR_VALID;
   logic [3:0]       BR_COND;
   logic [OFS_W-1:0] BR_OFS;
   logic [PC_W-1:0]  PC;
   logic             Pre_C;
   logic [3:0]       FLAGS;
   logic             SHADOW_VALID;
   logic             BR_DONE, BR_TAKEN;
   logic [PC_W-1:0]  BR_TARGET;

   cc_flag_unit #(.PC_W(PC_W), .OFS_W(OFS_W)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .Z_in(Z_in), .V_in(V_in), .C_in(C_in), .N_in(N_in),
      .FLAG_WE(FLAG_WE), .SET_C(SET_C), .CLR_C(CLR_C),
      .SAVE(SAVE), .RESTORE(RESTORE),
      .BR_VALID(BR_VALID), .BR_COND(BR_COND), .BR_OFS(BR_OFS), .PC(PC),
      .Pre_C(Pre_C), .FLAGS(FLAGS), .SHADOW_VALID(SHADOW_VALID),
      .BR_DONE(BR_DONE), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model: named flag bits, shadow as a queue of at most one entry.
   bit        mn, mz, mv, mc;
   bit [3:0]  shq[$];
   bit        m_done, m_taken;
   bit [15:0] m_tgt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit cond_true(input int cc, input bit n, input bit z, input bit v, input bit c);
      case (cc)
         0:  return z;
         1:  return !z;
         2:  return c;
         3:  return !c;
         4:  return n;
         5:  return !n;
         6:  return v;
         7:  return !v;
         8:  return c && !z;
         9:  return !c || z;
         10: return n == v;
         11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      mn = 0; mz = 0; mv = 0; mc = 0;
      shq.delete();
      m_done = 0; m_taken = 0; m_tgt = '0;
   endtask

   task automatic check_all(input string pfx);
      chk({pfx, "_flags"},  FLAGS, {mn, mz, mv, mc});
      chk({pfx, "_pre_c"},  Pre_C, mc);
      chk({pfx, "_shv"},    SHADOW_VALID, shq.size() != 0);
      chk({pfx, "_done"},   BR_DONE, m_done);
      chk({pfx, "_taken"},  BR_TAKEN, m_taken);
      chk({pfx, "_target"}, BR_TARGET, m_tgt);
   endtask

   task automatic idle();
      Z_in = 0; V_in = 0; C_in = 0; N_in = 0;
      FLAG_WE = 0; SET_C = 0; CLR_C = 0; SAVE = 0; RESTORE = 0;
      BR_VALID = 0; BR_COND = 0; BR_OFS = 0; PC = 0;
   endtask

   // Predict the edge from current inputs, clock it, then compare.
   task automatic tick(input string pfx);
      int  ofs;
      bit [3:0] saved;
      if (BR_VALID) begin
         ofs     = int'($signed(BR_OFS));
         m_done  = 1;
         m_taken = cond_true(int'(BR_COND), mn, mz, mv, mc);
         m_tgt   = 16'(int'(PC) + 1 + ofs);
      end else begin
         m_done  = 0;
         m_taken = 0;
      end
      if (RESTORE && shq.size() != 0) begin
         saved = shq.pop_front();
         {mn, mz, mv, mc} = saved;
      end else begin
         if (FLAG_WE[3]) mn = N_in;
         if (FLAG_WE[2]) mz = Z_in;
         if (FLAG_WE[1]) mv = V_in;
         if (SET_C && CLR_C) mc = mc;
         else if (SET_C)     mc = 1;
         else if (CLR_C)     mc = 0;
         else if (FLAG_WE[0]) mc = C_in;
      end
      if (SAVE && !RESTORE) begin
         shq.delete();
         shq.push_back({mn, mz, mv, mc});
      end
      @(posedge CLK);
      #1;
      check_all(pfx);
   endtask

   task automatic reset_dut();
      RST_N = 0;
      #1;
      model_reset();
      check_all("rst");
      @(negedge CLK);
      RST_N = 1;
   endtask

   initial begin
      idle();
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      check_all("reset");
      @(negedge CLK);
      RST_N = 1;

      // SUB 1234-2345: N=1 Z=0 V=0 C=0, then LT taken / GE not taken
      idle(); N_in = 1; FLAG_WE = 4'hF;
      tick("sub");
      chk("sub_flags_k", FLAGS, 4'b1000);
      idle(); BR_VALID = 1; BR_COND = 4'd11;
      tick("lt");
      chk("lt_taken_k", BR_TAKEN, 1'b1);
      BR_COND = 4'd10;
      tick("ge");
      chk("ge_taken_k", BR_TAKEN, 1'b0);
      idle();
      tick("idle1");

      // ADC FFFF+1: Z=1 C=1 with WE=0101, then SET_C+CLR_C holds C
      reset_dut();
      idle(); Z_in = 1; C_in = 1; FLAG_WE = 4'b0101;
      tick("adc");
      chk("adc_flags_k", FLAGS, 4'b0101);
      chk("adc_prec_k", Pre_C, 1'b1);
      idle(); SET_C = 1; CLR_C = 1;
      tick("setclr");
      chk("setclr_c_k", Pre_C, 1'b1);

      // Save / overwrite / restore / second restore
      idle(); SAVE = 1;
      tick("save");
      idle(); N_in = 1; FLAG_WE = 4'hF;
      tick("wr");
      chk("wr_flags_k", FLAGS, 4'b1000);
      idle(); RESTORE = 1; FLAG_WE = 4'hF;
      tick("rest1");
      chk("rest1_flags_k", FLAGS, 4'b0101);
      chk("rest1_shv_k", SHADOW_VALID, 1'b0);
      idle(); RESTORE = 1;
      tick("rest2");
      chk("rest2_flags_k", FLAGS, 4'b0101);

      // Target wrap and negative offset
      idle(); BR_VALID = 1; BR_COND = 4'd14; PC = 16'hFFFE; BR_OFS = 8'h01;
      tick("wrap");
      chk("wrap_tgt_k", BR_TARGET, 16'h0000);
      chk("wrap_taken_k", BR_TAKEN, 1'b1);
      PC = 16'h0010; BR_OFS = 8'hF0;
      tick("neg");
      chk("neg_tgt_k", BR_TARGET, 16'h0001);
      idle();
      tick("hold");
      chk("hold_tgt_k", BR_TARGET, 16'h0001);

      // Same-cycle flag write does not affect the branch
      reset_dut();
      idle(); BR_VALID = 1; BR_COND = 4'd0; FLAG_WE = 4'b0100; Z_in = 1;
      tick("eqwr");
      chk("eqwr_taken_k", BR_TAKEN, 1'b0);
      chk("eqwr_z_k", FLAGS[2], 1'b1);

      // Reset during the result cycle
      idle(); BR_VALID = 1; BR_COND = 4'd14; FLAG_WE = 4'hF; C_in = 1; N_in = 1;
      tick("prerst");
      idle();
      RST_N = 0;
      #1;
      chk("rst_done_k", BR_DONE, 1'b0);
      chk("rst_flags_k", FLAGS, 4'b0000);
      chk("rst_prec_k", Pre_C, 1'b0);
      model_reset();
      @(negedge CLK);
      RST_N = 1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         {N_in, Z_in, V_in, C_in} = 4'($urandom);
         FLAG_WE  = 4'($urandom);
         SET_C    = ($urandom_range(0, 5) == 0);
         CLR_C    = ($urandom_range(0, 5) == 0);
         SAVE     = ($urandom_range(0, 6) == 0);
         RESTORE  = ($urandom_range(0, 6) == 0);
         BR_VALID = ($urandom_range(0, 2) != 0);
         BR_COND  = 4'($urandom);
         BR_OFS   = 8'($urandom);
         PC       = 16'($urandom);
         tick("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cc_flag_unit.md
Name: cc_flag_unit

Overview:
- Consumer end of the ALU_CC flag outputs (Z, V, C, N).
- Latches the flags into the architectural condition-code register and returns the stored carry as Pre_C for ADC/SBB.
- Evaluates branch conditions against the stored flags and produces a registered branch decision and target.
- Holds a one-deep shadow copy of the flags for interrupt entry/return.

Parameters:
- PC_W, 16, program-counter and branch-target width.
- OFS_W, 8, branch offset width (two's complement).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- Z_in  in  1  ALU zero flag.
- V_in  in  1  ALU overflow flag.
- C_in  in  1  ALU carry flag.
- N_in  in  1  ALU negative flag.
- FLAG_WE  in  4  per-flag write enable; bit3=N, bit2=Z, bit1=V, bit0=C.
- SET_C  in  1  force C=1.
- CLR_C  in  1  force C=0.
- SAVE  in  1  copy FLAGS to shadow.
- RESTORE  in  1  copy shadow to FLAGS.
- BR_VALID  in  1  branch request this cycle.
- BR_COND  in  4  condition code.
- BR_OFS  in  OFS_W  signed word offset.
- PC  in  PC_W  address of the branch instruction.
- Pre_C  out  1  stored C; drives ALU_CC Pre_C.
- FLAGS  out  4  {N,Z,V,C} stored register.
- SHADOW_VALID  out  1  shadow holds saved flags.
- BR_DONE  out  1  one-cycle pulse: branch result valid.
- BR_TAKEN  out  1  condition true; valid while BR_DONE=1.
- BR_TARGET  out  PC_W  branch target; valid while BR_DONE=1.

Behaviour:
- Reset (RST_N=0, asynchronous): FLAGS=0, Pre_C=0, shadow=0, SHADOW_VALID=0, BR_DONE=0, BR_TAKEN=0, BR_TARGET=0. Any in-flight branch is discarded.
- Pre_C is combinational from FLAGS[0]. It always reflects the registered C, never the C_in of the current cycle.
- Flag update priority per clock edge, highest first:
  - RESTORE with SHADOW_VALID=1: FLAGS <= shadow and SHADOW_VALID <= 0. FLAG_WE, SET_C and CLR_C are ignored that cycle.
  - RESTORE with SHADOW_VALID=0: no effect. Evaluation continues with the next item.
  - Otherwise each flag whose FLAG_WE bit is set loads its *_in value.
  - SET_C overrides FLAG_WE[0]. CLR_C overrides FLAG_WE[0].
  - SET_C and CLR_C asserted together: C unchanged.
- SAVE: shadow <= value FLAGS will hold after this edge's update, and SHADOW_VALID <= 1. SAVE with valid shadow overwrites it. SAVE and RESTORE in the same cycle: RESTORE wins, SAVE ignored.
- Branch evaluation:
  - Latency is 1 cycle. BR_VALID sampled at edge k gives BR_DONE=1 during cycle k+1 with BR_TAKEN and BR_TARGET.
  - Back-to-back BR_VALID is supported: one result per cycle.
  - Conditions use FLAGS before the edge k update. A same-cycle flag write does not affect that branch.
- BR_COND decode:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C.
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V.
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- BR_TARGET = PC + 1 + sign_extend(BR_OFS), modulo 2^PC_W (wraps silently). It is computed regardless of BR_TAKEN.
- When BR_DONE=0, BR_TAKEN=0. BR_TARGET holds its last value.
- Reset asserted during a branch's latency cycle: BR_DONE stays 0.

Test Plan:
- After reset, FLAG_WE=4'hF with ALU_CC SUB on A=16'h1234, B=16'h2345 (Y=16'hEEEF; N=1, Z=0, V=0, C=0) -> FLAGS=4'b1000 next cycle, Pre_C=0. BR_COND=11 (LT) next -> BR_TAKEN=1; BR_COND=10 (GE) -> 0.
- ALU_CC ADC on A=16'hFFFF, B=16'h0001, Pre_C=0 (Y=0, Z=1, C=1), FLAG_WE=4'b0101 -> FLAGS=4'b0101, Pre_C=1. Then SET_C=1, CLR_C=1 together -> C stays 1.
- FLAGS=4'b0101, SAVE=1; then write FLAGS=4'b1000; then RESTORE=1 with FLAG_WE=4'hF -> FLAGS=4'b0101, SHADOW_VALID=0. A second RESTORE -> no change.
- PC=16'hFFFE, BR_OFS=8'h01, BR_COND=14 -> next cycle BR_DONE=1, BR_TAKEN=1, BR_TARGET=16'h0000. PC=16'h0010, BR_OFS=8'hF0 -> BR_TARGET=16'h0001.
- BR_VALID with BR_COND=0 and, same cycle, FLAG_WE[2]=1 with Z_in=1 while stored Z=0 -> BR_TAKEN=0, FLAGS.Z=1 after.
- BR_VALID at edge k, RST_N pulsed low in cycle k+1 -> BR_DONE=0, FLAGS=0, Pre_C=0 immediately.
